// File: rtl/prefetch_issue_scheduler_if.sv
// Candidate input, flush/throttle control and lower-level
// prefetch request port of the prefetch issue scheduler.
interface prefetch_issue_scheduler_if #(
  parameter int WIDTH           = 64,
  parameter int MAX_OUTSTANDING = 12
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic             pf_valid_i;
  logic [WIDTH-1:0] pf_address_i;
  logic             flush_i;
  logic             throttle_i;
  logic             lo_ready_i;
  logic             lo_done_i;
  logic             lo_prefetch_valid_o;
  logic [WIDTH-1:0] lo_prefetch_address_o;
  logic [OW-1:0]    outstanding_o;
  logic [15:0]      drop_count_o;

  modport master (
    output pf_valid_i,
    output pf_address_i,
    output flush_i,
    output throttle_i,
    output lo_ready_i,
    output lo_done_i,
    input  lo_prefetch_valid_o,
    input  lo_prefetch_address_o,
    input  outstanding_o,
    input  drop_count_o
  );

  modport slave (
    input  pf_valid_i,
    input  pf_address_i,
    input  flush_i,
    input  throttle_i,
    input  lo_ready_i,
    input  lo_done_i,
    output lo_prefetch_valid_o,
    output lo_prefetch_address_o,
    output outstanding_o,
    output drop_count_o
  );
endinterface

// File: rtl/prefetch_issue_scheduler.sv
// Prefetch issue scheduler: dedup FIFO, recent-line filter and
// MSHR-budget throttled valid/ready issue to the lower level.
module prefetch_issue_scheduler #(
  parameter int WIDTH           = 64,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 12,
  parameter int RECENT          = 4,
  parameter int LOGLINE         = 6
) (
  input logic clk,
  input logic rst,
  prefetch_issue_scheduler_if.slave bus
);
  localparam int LW = WIDTH - LOGLINE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [LW-1:0] line_t;
  typedef enum logic {IDLE, REQ} state_t;

  state_t        state;
  state_t        state_nxt;
  line_t         fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  line_t         out_line;
  line_t         recent_q [RECENT];
  logic [RECENT-1:0] recent_vld;
  logic [OW-1:0] outstanding;
  logic [15:0]   drop_cnt;

  line_t cand;
  logic  fifo_hit;
  logic  recent_hit;
  logic  out_hit;
  logic  dup;
  logic  full;
  logic  push;
  logic  drop;
  logic  pop;
  logic  hs;
  logic  done_dec;
  logic  unused_low;

  assign cand       = bus.pf_address_i[WIDTH-1:LOGLINE];
  assign unused_low = ^bus.pf_address_i[LOGLINE-1:0];
  assign full       = (count == CW'(DEPTH));

  // only slots between rd_ptr and rd_ptr+count hold live lines
  always_comb begin
    logic [PW-1:0] age;
    fifo_hit = 1'b0;
    age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - rd_ptr;
      if ((CW'(age) < count) && (fifo_q[i] == cand))
        fifo_hit = 1'b1;
    end
  end

  always_comb begin
    recent_hit = 1'b0;
    for (int i = 0; i < RECENT; i++) begin
      if (recent_vld[i] && (recent_q[i] == cand))
        recent_hit = 1'b1;
    end
  end

  assign out_hit  = (state == REQ) && (out_line == cand);
  assign dup      = fifo_hit | recent_hit | out_hit;
  assign push     = bus.pf_valid_i & ~bus.flush_i & ~dup & ~full;
  assign drop     = bus.pf_valid_i & ~bus.flush_i & ~dup & full;
  assign done_dec = bus.lo_done_i & (outstanding != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !bus.throttle_i &&
            (outstanding < OW'(MAX_OUTSTANDING)) &&
            !bus.flush_i) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        hs = bus.lo_ready_i;
        if (bus.lo_ready_i || bus.flush_i)
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_line    <= '0;
      recent_vld  <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= '0;
      for (int i = 0; i < RECENT; i++)
        recent_q[i] <= '0;
    end else begin
      if (bus.flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr] <= cand;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          out_line <= fifo_q[rd_ptr];
          rd_ptr   <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
      if (hs) begin
        for (int i = RECENT - 1; i > 0; i--)
          recent_q[i] <= recent_q[i-1];
        recent_q[0] <= out_line;
        recent_vld  <= {recent_vld[RECENT-2:0], 1'b1};
      end
      // a same-cycle handshake lands first, then flush wipes it
      if (bus.flush_i)
        recent_vld <= '0;
      unique case ({hs, done_dec})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.lo_prefetch_valid_o   = (state == REQ);
  assign bus.lo_prefetch_address_o = {out_line, {LOGLINE{1'b0}}};
  assign bus.outstanding_o         = outstanding;
  assign bus.drop_count_o          = drop_cnt;
endmodule
